// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC SPI output stage.
// Holds the FSM state enum, frame geometry and the offset-binary midscale.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int FRAME_W = 16;
    localparam int CODE_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;

    localparam logic [CODE_W-1:0] MIDSCALE = 12'd2048;

endpackage

// File: rtl/dac_spi_out_sclk_gen.sv
// SPI clock generator: half-period counter that runs only while enabled.
// Ports: clk, rst, en (frame active), sclk (idles high), fall_tick/rise_tick
// (one-cycle strobes in the cycle before sclk changes level).
import dac_pkg::*;

module sclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = en && (cnt == CW'(DIV - 1));
    assign fall_tick = wrap && sclk;
    assign rise_tick = wrap && !sclk;

    // Leaving the enabled state parks the clock high with a fresh count,
    // so every frame starts with a full half-period before the first fall.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_out.sv
// Captures one signed Qmag.pres sample per start, clamps it to a 12-bit
// offset-binary code and shifts a 16-bit frame MSB-first to the DAC.
// Ports: clk, rst, data_i, start in; busy, done, sat, overrun, sclk,
// sync_n, sdata out (all registered).
import dac_pkg::*;

module dac_spi_out #(
    parameter int largo = 24,
    parameter int mag   = 8,
    parameter int pres  = 16,
    parameter int DIV   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [largo:0] data_i,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sat,
    output logic              overrun,
    output logic              sclk,
    output logic              sync_n,
    output logic              sdata
);

    localparam int SH = pres - 11;

    localparam logic signed [largo:0] SMAX = $signed((largo+1)'(2047));
    localparam logic signed [largo:0] SMIN = $signed((largo+1)'(-2048));

    state_t state;
    state_t next;

    logic signed [largo:0]  s;
    logic [CODE_W-1:0]      clamp;
    logic                   sat_c;
    logic [FRAME_W-1:0]     frame_c;
    logic [FRAME_W-2:0]     shreg;
    logic [4:0]             bitcnt;
    logic                   fall_tick;
    logic                   rise_tick;
    logic                   accept;

    // Integer bits beyond 12 only matter for detecting saturation.
    always_comb begin
        s     = data_i >>> SH;
        clamp = s[CODE_W-1:0];
        sat_c = 1'b0;
        if (s > SMAX) begin
            clamp = 12'h7ff;
            sat_c = 1'b1;
        end else if (s < SMIN) begin
            clamp = 12'h800;
            sat_c = 1'b1;
        end
        frame_c = {2'b00, PD_NORMAL, clamp + MIDSCALE};
    end

    assign accept = (state == IDLE) && start;

    sclk_gen #(
        .DIV(DIV)
    ) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .en       (state == SHIFT),
        .sclk     (sclk),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (start) next = SHIFT;
            SHIFT:   if (rise_tick && bitcnt == 5'd15) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            overrun <= 1'b0;
            sync_n  <= 1'b1;
            sdata   <= 1'b0;
            shreg   <= '0;
            bitcnt  <= '0;
        end else begin
            busy   <= (next != IDLE);
            done   <= (next == DONE);
            sync_n <= (next != SHIFT);
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                shreg  <= frame_c[FRAME_W-2:0];
                sdata  <= frame_c[FRAME_W-1];
                sat    <= sat_c;
                bitcnt <= '0;
            end else if (state == SHIFT && rise_tick) begin
                // Zero-fill leaves sdata low once the last bit is gone.
                shreg  <= {shreg[FRAME_W-3:0], 1'b0};
                sdata  <= shreg[FRAME_W-2];
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out with DIV=2 and default widths.
// Decodes SPI frames on sclk falling edges and checks handshake timing.
module tb_dac_spi_out;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [24:0] data_i = '0;
    logic               start = 1'b0;
    logic               busy, done, sat, overrun, sclk, sync_n, sdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [24:0] d;
        logic [15:0]        f;
        logic               s;
    } vec_t;

    vec_t tbl[5];

    dac_spi_out #(
        .largo(24),
        .mag  (8),
        .pres (16),
        .DIV  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .sat    (sat),
        .overrun(overrun),
        .sclk   (sclk),
        .sync_n (sync_n),
        .sdata  (sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one frame in the current cycle (A) and follows it to A+66.
    task automatic run_frame(input logic signed [24:0] d,
                             input logic [15:0] exp_f, input logic exp_s,
                             input int extra_at, input logic exp_ovr);
        logic [15:0] acc;
        int          low;
        int          done_at;
        int          n;
        logic        prev_sclk;
        acc       = '0;
        low       = 0;
        done_at   = 0;
        prev_sclk = 1'b1;
        data_i    = d;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check("busy_a1", busy, 1);
        check("sync_a1", sync_n, 0);
        check("sclk_a1", sclk, 1);
        while (n < 200 && done_at == 0) begin
            if (!sync_n) low++;
            if (!sync_n && prev_sclk && !sclk) acc = {acc[14:0], sdata};
            if (done) done_at = n;
            prev_sclk = sclk;
            if (n == extra_at) begin
                start  = 1'b1;
                data_i = 25'sh010000;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("done_at", done_at, 65);
        check("sync_low", low, 64);
        check("frame", acc, exp_f);
        check("sat", sat, exp_s);
        check("busy_end", busy, 0);
        check("done_pulse", done, 0);
        check("overrun", overrun, exp_ovr);
    endtask

    initial begin
        logic [15:0] acc;
        int          started;
        int          idx;
        int          last_fall;
        int          saw_done;
        logic        prev_sync;
        logic        prev_sclk;

        tbl[0] = '{25'sd0,          16'h0800, 1'b0};
        tbl[1] = '{25'sh008000,     16'h0C00, 1'b0};
        tbl[2] = '{-25'sd65536,     16'h0000, 1'b0};
        tbl[3] = '{25'sh010000,     16'h0FFF, 1'b1};
        tbl[4] = '{-25'sd13107200,  16'h0000, 1'b1};

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat, 0);
        check("rst_ovr", overrun, 0);
        check("rst_sclk", sclk, 1);
        check("rst_sync", sync_n, 1);
        check("rst_sdata", sdata, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].d, tbl[i].f, tbl[i].s, 0, 1'b0);
        end

        // Start during a frame: frame untouched, overrun sticks.
        run_frame(25'sd0, 16'h0800, 1'b0, 10, 1'b1);
        run_frame(tbl[1].d, tbl[1].f, tbl[1].s, 0, 1'b1);

        // Reset in the middle of a frame.
        data_i = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 20; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_sync", sync_n, 1);
        check("mid_rst_sclk", sclk, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovr", overrun, 0);
        saw_done = 0;
        for (int n = 0; n < 6; n++) begin
            if (done) saw_done = 1;
            tick();
        end
        check("mid_rst_nodone", saw_done, 0);
        run_frame(tbl[3].d, tbl[3].f, tbl[3].s, 0, 1'b0);

        // Back-to-back with start held high.
        data_i    = tbl[0].d;
        start     = 1'b1;
        started   = 0;
        idx       = 0;
        last_fall = 0;
        acc       = '0;
        prev_sync = 1'b1;
        prev_sclk = 1'b1;
        for (int n = 0; n < 300 && idx < 3; n++) begin
            tick();
            if (prev_sync && !sync_n) begin
                if (started > 0) check("b2b_period", n - last_fall, 66);
                last_fall = n;
                started++;
                acc = '0;
                if (started < 3) data_i = tbl[started].d;
            end
            if (!sync_n && prev_sclk && !sclk) acc = {acc[14:0], sdata};
            if (!prev_sync && sync_n) begin
                check("b2b_frame", acc, tbl[idx].f);
                idx++;
            end
            prev_sync = sync_n;
            prev_sclk = sclk;
        end
        start = 1'b0;
        check("b2b_count", idx, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
